// File: rtl/pw_cracker_pkg.sv
`default_nettype none
// ============================================================================
// pw_cracker_pkg : shared constants, FSM state type and index-to-ASCII map
// Rev 1.0
// ============================================================================
package pw_cracker_pkg;

  localparam int PW_LEN     = 4;
  localparam int ALPHA_SIZE = 36;
  localparam int IDX_W      = 6;
  localparam int DATA_W     = PW_LEN * 8;
  localparam int CNT_W      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 0..25 -> 'a'..'z', 26..35 -> '0'..'9'
  function automatic logic [7:0] idx_to_ascii(input logic [IDX_W-1:0] idx);
    logic [7:0] w_idx;
    w_idx = {2'b00, idx};
    if (idx < IDX_W'(26))
      return 8'h61 + w_idx;
    else
      return 8'h30 + (w_idx - 8'd26);
  endfunction

endpackage
`default_nettype wire

// File: rtl/password_candidate_gen_if.sv
`default_nettype none
// ============================================================================
// password_candidate_gen_if : control and candidate-stream bundle
// Rev 1.0  (cand_count present only when CAND_COUNT_EN is defined)
// ============================================================================
interface password_candidate_gen_if;
  import pw_cracker_pkg::*;

  logic              start;
  logic [IDX_W-1:0]  from;
  logic [IDX_W-1:0]  to;
  logic              stop;
  logic              cand_valid;
  logic              cand_ready;
  logic [DATA_W-1:0] cand_data;
  logic              busy;
  logic              done;
  logic              range_err;
`ifdef CAND_COUNT_EN
  logic [CNT_W-1:0]  cand_count;
`endif

  modport master (
    input  start, from, to, stop, cand_ready,
`ifdef CAND_COUNT_EN
    output cand_count,
`endif
    output cand_valid, cand_data, busy, done, range_err
  );

  modport slave (
    output start, from, to, stop, cand_ready,
`ifdef CAND_COUNT_EN
    input  cand_count,
`endif
    input  cand_valid, cand_data, busy, done, range_err
  );

endinterface
`default_nettype wire

// File: rtl/pw_char_map.sv
`default_nettype none
// ============================================================================
// pw_char_map : combinational alphabet index -> ASCII byte
// Rev 1.0
// ============================================================================
module pw_char_map
  import pw_cracker_pkg::*;
(
  input  wire logic [IDX_W-1:0] i_idx,
  output logic      [7:0]       o_ascii
);

  assign o_ascii = idx_to_ascii(i_idx);

endmodule
`default_nettype wire

// File: rtl/password_candidate_gen.sv
`default_nettype none
// ============================================================================
// password_candidate_gen : odometer enumerator of PW_LEN-char candidates
// Rev 1.0  (optional transfer counter: define CAND_COUNT_EN)
// ============================================================================
module password_candidate_gen
  import pw_cracker_pkg::*;
(
  input  wire logic                 clk,
  input  wire logic                 rst,
  password_candidate_gen_if.master  bus
);

  state_t                        r_state, w_state_nxt;
  logic [PW_LEN-1:0][IDX_W-1:0]  r_idx, w_idx_nxt, w_idx_inc;
  logic [IDX_W-1:0]              r_to, w_to_nxt;
  logic                          r_valid, w_valid_nxt;
  logic                          r_busy, w_busy_nxt;
  logic                          r_done, w_done_nxt;
  logic                          r_rerr, w_rerr_nxt;
  logic                          w_cnt_clr;
  logic                          w_xfer;
  logic                          w_carry;
  logic                          w_last;
  logic                          w_range_ok;
  logic [DATA_W-1:0]             w_data;

  assign w_xfer     = r_valid & bus.cand_ready;
  assign w_range_ok = (bus.from <= bus.to) && (bus.to < IDX_W'(ALPHA_SIZE));
  assign w_last     = w_carry && (r_idx[0] == r_to);

  // Ripple increment from the last char; w_carry ends high when every
  // non-first position sits at ALPHA_SIZE-1.
  always_comb begin
    w_idx_inc = r_idx;
    w_carry   = 1'b1;
    for (int i = PW_LEN - 1; i >= 1; i--) begin
      if (w_carry) begin
        if (r_idx[i] == IDX_W'(ALPHA_SIZE - 1)) begin
          w_idx_inc[i] = '0;
        end else begin
          w_idx_inc[i] = r_idx[i] + IDX_W'(1);
          w_carry      = 1'b0;
        end
      end
    end
    if (w_carry)
      w_idx_inc[0] = r_idx[0] + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_to_nxt    = r_to;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_rerr_nxt  = r_rerr;
    w_cnt_clr   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          if (w_range_ok) begin
            w_state_nxt  = RUN;
            w_idx_nxt    = '0;
            w_idx_nxt[0] = bus.from;
            w_to_nxt     = bus.to;
            w_valid_nxt  = 1'b1;
            w_busy_nxt   = 1'b1;
            w_done_nxt   = 1'b0;
            w_rerr_nxt   = 1'b0;
            w_cnt_clr    = 1'b1;
          end else begin
            w_state_nxt  = DONE;
            w_valid_nxt  = 1'b0;
            w_busy_nxt   = 1'b0;
            w_done_nxt   = 1'b1;
            w_rerr_nxt   = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.stop || (w_xfer && w_last)) begin
          w_state_nxt = DONE;
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else if (w_xfer) begin
          w_idx_nxt = w_idx_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_to    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rerr  <= 1'b0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_to    <= w_to_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_rerr  <= w_rerr_nxt;
    end
  end

  for (genvar g = 0; g < PW_LEN; g++) begin : g_char
    pw_char_map u_map (
      .i_idx   (r_idx[g]),
      .o_ascii (w_data[(PW_LEN-g)*8-1 -: 8])
    );
  end

  // Outside a valid beat the bus shows zero rather than stale indices.
  assign bus.cand_data  = r_valid ? w_data : '0;
  assign bus.cand_valid = r_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.range_err  = r_rerr;

`ifdef CAND_COUNT_EN
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_cnt_clr)
      w_cnt_nxt = '0;
    else if (w_xfer && (r_cnt != '1))
      w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else
      r_cnt <= w_cnt_nxt;
  end

  assign bus.cand_count = r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_password_candidate_gen.sv
`default_nettype none
// ============================================================================
// tb_password_candidate_gen : directed stimulus, behavioural candidate model
// Rev 1.0
// ============================================================================
module tb_password_candidate_gen;
  import pw_cracker_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  password_candidate_gen_if bus ();

  password_candidate_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          nchk = 0;
  int          nerr = 0;
  bit          chk_en = 1'b0;
  logic [31:0] log_q[$];
  logic [31:0] held;

  bit          m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_rerr = 1'b0;
  int          m_n = 0, m_total = 0, m_from = 0;
  logic [31:0] m_cnt = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Candidate number n of a run is a base-36 number whose top digit is offset by from.
  function automatic logic [31:0] exp_cand(input int f, input int n);
    string       al;
    logic [31:0] r;
    al = "abcdefghijklmnopqrstuvwxyz0123456789";
    r[31:24] = al.getc(f + n / 46656);
    r[23:16] = al.getc((n / 1296) % 36);
    r[15:8]  = al.getc((n / 36) % 36);
    r[7:0]   = al.getc(n % 36);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_rerr <= 1'b0;
      m_n <= 0; m_cnt <= '0;
    end else if (bus.start && !m_busy) begin
      if (bus.from <= bus.to && bus.to < 6'd36) begin
        m_from  <= int'(bus.from);
        m_total <= (int'(bus.to) - int'(bus.from) + 1) * 46656;
        m_n <= 0; m_cnt <= '0;
        m_valid <= 1'b1; m_busy <= 1'b1; m_done <= 1'b0; m_rerr <= 1'b0;
      end else begin
        m_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b1; m_rerr <= 1'b1;
      end
    end else if (m_busy) begin
      if (m_valid && bus.cand_ready && m_cnt != 32'hFFFF_FFFF)
        m_cnt <= m_cnt + 32'd1;
      if (bus.stop) begin
        m_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b1;
      end else if (m_valid && bus.cand_ready) begin
        if (m_n + 1 == m_total) begin
          m_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b1;
        end else begin
          m_n <= m_n + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", bus.cand_valid, m_valid);
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("range_err", bus.range_err, m_rerr);
      if (m_valid)
        chk("data", bus.cand_data, exp_cand(m_from, m_n));
`ifdef CAND_COUNT_EN
      chk("count", bus.cand_count, m_cnt);
`endif
      if (bus.cand_valid && bus.cand_ready)
        log_q.push_back(bus.cand_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      step();
      k++;
    end
    if (log_q.size() < n)
      chk("timeout_log", log_q.size(), n);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!bus.done && k < budget) begin
      step();
      k++;
    end
    if (!bus.done)
      chk("timeout_done", bus.done, 1);
  endtask

  task automatic go(input logic [5:0] f, input logic [5:0] t);
    bus.from  = f;
    bus.to    = t;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.from = '0; bus.to = '0; bus.stop = 1'b0; bus.cand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_valid", bus.cand_valid, 0);
    chk("rst_data", bus.cand_data, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    step(); step();
    chk("post_rst_valid", bus.cand_valid, 0);
    chk("post_rst_busy", bus.busy, 0);

    bus.cand_ready = 1'b1;
    go(6'd4, 6'd4);
    chk("e_first", bus.cand_data, 32'h6561_6161);
    wait_done(50000);
    chk("e_count", log_q.size(), 46656);
    chk("e_log0", log_q[0], 32'h6561_6161);
    chk("e_log1", log_q[1], 32'h6561_6162);
    chk("e_last", log_q[log_q.size()-1], 32'h6539_3939);
    chk("e_busy_end", bus.busy, 0);

    log_q.delete();
    go(6'd0, 6'd0);
    wait_log(40, 200);
    chk("wrap_aaaz", log_q[25], 32'h6161_617A);
    chk("wrap_aaa0", log_q[26], 32'h6161_6130);
    chk("wrap_aaa9", log_q[35], 32'h6161_6139);
    chk("carry_aaba", log_q[36], 32'h6161_6261);
    bus.cand_ready = 1'b0;
    held = bus.cand_data;
    repeat (3) begin
      step();
      chk("bp_valid", bus.cand_valid, 1);
      chk("bp_hold", bus.cand_data, held);
    end
    bus.cand_ready = 1'b1;
    wait_log(45, 50);
    chk("bp_resume", log_q[40], 32'h6161_6265);
    go(6'd9, 6'd9);
    wait_log(50, 50);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("stop_valid", bus.cand_valid, 0);
    chk("stop_done", bus.done, 1);
    chk("stop_busy", bus.busy, 0);

    bus.stop = 1'b1;
    go(6'd2, 6'd2);
    bus.stop = 1'b0;
    chk("ss_valid", bus.cand_valid, 1);
    chk("ss_data", bus.cand_data, 32'h6361_6161);
    step(); step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;

    go(6'd5, 6'd2);
    chk("bad_done", bus.done, 1);
    chk("bad_rerr", bus.range_err, 1);
    repeat (3) step();
    go(6'd0, 6'd36);
    chk("bad_to_rerr", bus.range_err, 1);
    chk("bad_to_valid", bus.cand_valid, 0);

    log_q.delete();
    go(6'd1, 6'd1);
    wait_log(100, 200);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.cand_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_data", bus.cand_data, 0);
    step(); step();
    rst = 1'b0;
    step();
    log_q.delete();
    go(6'd1, 6'd1);
    chk("re_first", bus.cand_data, 32'h6261_6161);
`ifdef CAND_COUNT_EN
    chk("re_count0", bus.cand_count, 0);
`endif
    wait_log(1, 5);
`ifdef CAND_COUNT_EN
    chk("re_count1", bus.cand_count, 1);
`endif
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    bus.cand_ready = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
